// File: rtl/alu.sv
// Five-stage MIPS-32 pipeline: fetch, decode, execute, memory, writeback.
// Branches and jumps resolve in execute and flush the two younger slots.
// Results are forwarded from memory/writeback, and a load-use pair stalls for one cycle.
module alu #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic clock,
  input  logic reset_n
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  // Memories (word index = byte address >> 2) and register file
  logic [31:0] instrMemory [0:IMEM_WORDS-1];
  logic [31:0] dataMemory  [0:DMEM_WORDS-1];
  logic [31:0] gr          [0:31];

  // Fetch
  logic [31:0] PC, pc_d;
  // Fetch -> decode
  logic [31:0] instr, instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  // Decode -> execute
  logic [31:0] ex_instr_q, ex_instr_d;
  logic [31:0] ex_pc4_q, ex_pc4_d;
  logic [31:0] ex_rs_val_q, ex_rs_val_d;
  logic [31:0] ex_rt_val_q, ex_rt_val_d;
  // Execute -> memory
  logic        mem_wr_q, mem_wr_d, mem_lw_q, mem_lw_d, mem_sw_q, mem_sw_d;
  logic [4:0]  mem_dst_q, mem_dst_d;
  logic [31:0] mem_alu_q, mem_alu_d, mem_sdata_q, mem_sdata_d;
  // Memory -> writeback
  logic        wb_wr_q, wb_wr_d, wb_lw_q, wb_lw_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic [31:0] wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;

  // Stage-visible datapath names
  logic [31:0] srcA, srcB, result;
  logic [31:0] ALUResult [0:1];
  logic [31:0] writeData [0:1];
  logic [31:0] readData  [0:1];

  // Decode-stage signals
  logic [31:0] id_rs_val, id_rt_val;
  logic        stall;

  // Execute-stage signals
  logic [5:0]  ex_op, ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt, ex_dst;
  logic [31:0] ex_sext, ex_zext, fwd_a, fwd_b;
  logic [31:0] ex_alu, ex_sdata, ex_target;
  logic        ex_wr, ex_lw, ex_sw, ex_taken;

  // Memory-stage signals
  logic [31:0] mem_rdata, mem_fwd;

  // Decode: register read (a same-cycle writeback is visible), load-use detection
  always_comb begin
    id_rs_val = gr[instr[25:21]];
    id_rt_val = gr[instr[20:16]];
    if (wb_wr_q && (wb_dst_q == instr[25:21])) id_rs_val = result;
    if (wb_wr_q && (wb_dst_q == instr[20:16])) id_rt_val = result;
    stall = ex_lw && (ex_dst != 5'd0) &&
            ((ex_dst == instr[25:21]) || (ex_dst == instr[20:16]));
  end

  // Memory stage: load data read and the value forwarded back to execute
  always_comb begin
    mem_rdata = dataMemory[mem_alu_q[DAW+1:2]];
    mem_fwd   = mem_lw_q ? mem_rdata : mem_alu_q;
  end

  // Execute: operand forwarding, ALU, branch/jump resolution
  always_comb begin
    ex_op    = ex_instr_q[31:26];
    ex_rs    = ex_instr_q[25:21];
    ex_rt    = ex_instr_q[20:16];
    ex_rd    = ex_instr_q[15:11];
    ex_shamt = ex_instr_q[10:6];
    ex_funct = ex_instr_q[5:0];
    ex_sext  = {{16{ex_instr_q[15]}}, ex_instr_q[15:0]};
    ex_zext  = {16'h0000, ex_instr_q[15:0]};

    // Memory stage is younger than writeback, so it takes priority
    fwd_a = ex_rs_val_q;
    if (wb_wr_q && (wb_dst_q == ex_rs))   fwd_a = result;
    if (mem_wr_q && (mem_dst_q == ex_rs)) fwd_a = mem_fwd;
    fwd_b = ex_rt_val_q;
    if (wb_wr_q && (wb_dst_q == ex_rt))   fwd_b = result;
    if (mem_wr_q && (mem_dst_q == ex_rt)) fwd_b = mem_fwd;

    srcA      = fwd_a;
    srcB      = fwd_b;
    ex_alu    = '0;
    ex_dst    = '0;
    ex_wr     = 1'b0;
    ex_lw     = 1'b0;
    ex_sw     = 1'b0;
    ex_taken  = 1'b0;
    ex_sdata  = fwd_b;
    ex_target = ex_pc4_q + {ex_sext[29:0], 2'b00};

    case (ex_op)
      6'h00: begin
        ex_dst = ex_rd;
        ex_wr  = 1'b1;
        case (ex_funct)
          6'h20, 6'h21: ex_alu = srcA + srcB;
          6'h22, 6'h23: ex_alu = srcA - srcB;
          6'h24:        ex_alu = srcA & srcB;
          6'h25:        ex_alu = srcA | srcB;
          6'h26:        ex_alu = srcA ^ srcB;
          6'h27:        ex_alu = ~(srcA | srcB);
          6'h2A:        ex_alu = {31'd0, ($signed(srcA) < $signed(srcB))};
          6'h00:        ex_alu = srcB << ex_shamt;
          6'h02:        ex_alu = srcB >> ex_shamt;
          6'h03:        ex_alu = $signed(srcB) >>> ex_shamt;
          6'h04:        ex_alu = srcB << srcA[4:0];
          6'h06:        ex_alu = srcB >> srcA[4:0];
          6'h07:        ex_alu = $signed(srcB) >>> srcA[4:0];
          6'h08: begin
            ex_wr     = 1'b0;
            ex_taken  = 1'b1;
            ex_target = srcA;
          end
          default:      ex_wr = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin
        srcB   = ex_sext;
        ex_alu = srcA + srcB;
        ex_dst = ex_rt;
        ex_wr  = 1'b1;
      end
      6'h0C: begin
        srcB   = ex_zext;
        ex_alu = srcA & srcB;
        ex_dst = ex_rt;
        ex_wr  = 1'b1;
      end
      6'h0D: begin
        srcB   = ex_zext;
        ex_alu = srcA | srcB;
        ex_dst = ex_rt;
        ex_wr  = 1'b1;
      end
      6'h23: begin
        srcB   = ex_sext;
        ex_alu = srcA + srcB;
        ex_dst = ex_rt;
        ex_wr  = 1'b1;
        ex_lw  = 1'b1;
      end
      6'h2B: begin
        srcB   = ex_sext;
        ex_alu = srcA + srcB;
        ex_sw  = 1'b1;
      end
      6'h04: ex_taken = (srcA == srcB);
      6'h05: ex_taken = (srcA != srcB);
      6'h02: begin
        ex_taken  = 1'b1;
        ex_target = {ex_pc4_q[31:28], ex_instr_q[25:0], 2'b00};
      end
      6'h03: begin
        ex_taken  = 1'b1;
        ex_target = {ex_pc4_q[31:28], ex_instr_q[25:0], 2'b00};
        ex_alu    = ex_pc4_q;
        ex_dst    = 5'd31;
        ex_wr     = 1'b1;
      end
      default: ;
    endcase

    // gr[0] writes are dropped here so forwarding never matches register 0
    if (ex_dst == 5'd0) ex_wr = 1'b0;
  end

  // Stage views of the ALU result
  always_comb begin
    ALUResult[0] = ex_alu;
    ALUResult[1] = mem_alu_q;
  end

  // Stage views of the store data
  always_comb begin
    writeData[0] = ex_sdata;
    writeData[1] = mem_sdata_q;
  end

  // Stage views of the load data and the writeback value
  always_comb begin
    readData[0] = mem_rdata;
    readData[1] = wb_rdata_q;
    result      = wb_lw_q ? readData[1] : wb_alu_q;
  end

  // Next-state: a taken transfer flushes fetch/decode; a load-use stall holds them and bubbles execute
  always_comb begin
    pc_d        = PC + 32'd4;
    instr_d     = instrMemory[PC[IAW+1:2]];
    id_pc4_d    = PC + 32'd4;
    ex_instr_d  = instr;
    ex_pc4_d    = id_pc4_q;
    ex_rs_val_d = id_rs_val;
    ex_rt_val_d = id_rt_val;
    if (ex_taken) begin
      pc_d        = ex_target;
      instr_d     = '0;
      id_pc4_d    = '0;
      ex_instr_d  = '0;
      ex_pc4_d    = '0;
      ex_rs_val_d = '0;
      ex_rt_val_d = '0;
    end else if (stall) begin
      pc_d        = PC;
      instr_d     = instr;
      id_pc4_d    = id_pc4_q;
      ex_instr_d  = '0;
      ex_pc4_d    = '0;
      ex_rs_val_d = '0;
      ex_rt_val_d = '0;
    end
    mem_wr_d    = ex_wr;
    mem_lw_d    = ex_lw;
    mem_sw_d    = ex_sw;
    mem_dst_d   = ex_dst;
    mem_alu_d   = ALUResult[0];
    mem_sdata_d = writeData[0];
    wb_wr_d     = mem_wr_q;
    wb_lw_d     = mem_lw_q;
    wb_dst_d    = mem_dst_q;
    wb_alu_d    = ALUResult[1];
    wb_rdata_d  = readData[0];
  end

  // Pipeline registers; reset empties every stage to a nop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      PC          <= '0;
      instr       <= '0;
      id_pc4_q    <= '0;
      ex_instr_q  <= '0;
      ex_pc4_q    <= '0;
      ex_rs_val_q <= '0;
      ex_rt_val_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_lw_q    <= 1'b0;
      mem_sw_q    <= 1'b0;
      mem_dst_q   <= '0;
      mem_alu_q   <= '0;
      mem_sdata_q <= '0;
      wb_wr_q     <= 1'b0;
      wb_lw_q     <= 1'b0;
      wb_dst_q    <= '0;
      wb_alu_q    <= '0;
      wb_rdata_q  <= '0;
    end else begin
      PC          <= pc_d;
      instr       <= instr_d;
      id_pc4_q    <= id_pc4_d;
      ex_instr_q  <= ex_instr_d;
      ex_pc4_q    <= ex_pc4_d;
      ex_rs_val_q <= ex_rs_val_d;
      ex_rt_val_q <= ex_rt_val_d;
      mem_wr_q    <= mem_wr_d;
      mem_lw_q    <= mem_lw_d;
      mem_sw_q    <= mem_sw_d;
      mem_dst_q   <= mem_dst_d;
      mem_alu_q   <= mem_alu_d;
      mem_sdata_q <= mem_sdata_d;
      wb_wr_q     <= wb_wr_d;
      wb_lw_q     <= wb_lw_d;
      wb_dst_q    <= wb_dst_d;
      wb_alu_q    <= wb_alu_d;
      wb_rdata_q  <= wb_rdata_d;
    end
  end

  // Register file write; gr[0] is never a destination
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 32; i++) gr[i] <= '0;
    end else if (wb_wr_q) begin
      gr[wb_dst_q] <= result;
    end
  end

  // Data memory store port; deliberately untouched by reset
  always_ff @(posedge clock) begin
    if (mem_sw_q) dataMemory[ALUResult[1][DAW+1:2]] <= writeData[1];
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the alu pipeline: loads a program, pushes the
// expected writeback sequence into a scoreboard and compares every writeback.
module tb_alu;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] v;
  } wb_t;

  logic clock = 1'b0;
  logic reset_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  wb_t exp_q[$];
  wb_t pass[$];
  logic [31:0] prog [0:42];
  logic mon_on = 1'b0;
  logic seen_8c = 1'b0, seen_9c = 1'b0, seen_ret = 1'b0;

  alu #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clock   (clock),
    .reset_n (reset_n)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic add_exp(input logic [4:0] r, input logic [31:0] v);
    pass.push_back({r, v});
  endtask

  task automatic push_pass();
    foreach (pass[i]) exp_q.push_back(pass[i]);
  endtask

  task automatic drain_to(input string tag, input int unsigned target, input int unsigned budget);
    for (int unsigned c = 0; c < budget && exp_q.size() > target; c++) @(negedge clock);
    check(tag, exp_q.size(), target);
  endtask

  // Writeback monitor: every register write is matched against the scoreboard
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (dut.PC == 32'h8C) seen_8c = 1'b1;
      if (dut.PC == 32'h9C) seen_9c = 1'b1;
      if (seen_9c && dut.PC == 32'h0) seen_ret = 1'b1;
      if (mon_on && dut.wb_wr_q) begin
        if (exp_q.size() == 0) begin
          check("wb_extra", {27'd0, dut.wb_dst_q}, 32'd0);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          check("wb_dst", {27'd0, dut.wb_dst_q}, {27'd0, e.r});
          check("wb_val", dut.result, e.v);
        end
      end
    end
  end

  initial begin
    logic [31:0] acc;
    int unsigned bad;
    reset_n = 1'b0;

    // Program
    for (int i = 0; i < 43; i++) prog[i] = enc_i(6'h08, 5'd0, 5'd5, 16'h0BAD);
    prog[0]  = enc_i(6'h23, 5'd0, 5'd1, 16'h0000);
    prog[1]  = enc_i(6'h23, 5'd0, 5'd2, 16'h0004);
    prog[2]  = enc_i(6'h2B, 5'd0, 5'd0, 16'h0008);
    prog[3]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    prog[4]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h22);
    prog[5]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    prog[6]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h23);
    prog[7]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h24);
    prog[8]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
    prog[9]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h27);
    prog[10] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h26);
    prog[11] = enc_i(6'h0C, 5'd0, 5'd3, 16'h1111);
    prog[12] = enc_i(6'h0D, 5'd0, 5'd3, 16'h1111);
    prog[13] = enc_r(5'd0, 5'd1, 5'd3, 5'd1, 6'h00);
    prog[14] = enc_r(5'd0, 5'd1, 5'd3, 5'd1, 6'h02);
    prog[15] = enc_r(5'd0, 5'd1, 5'd3, 5'd1, 6'h03);
    prog[16] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h04);
    prog[17] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h06);
    prog[18] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h07);
    prog[19] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A);
    prog[20] = enc_i(6'h08, 5'd0, 5'd8, 16'hFFFF);
    prog[21] = enc_i(6'h09, 5'd8, 5'd9, 16'h0002);
    prog[22] = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFF);
    prog[23] = enc_i(6'h23, 5'd0, 5'd4, 16'h0000);
    prog[24] = enc_r(5'd4, 5'd4, 5'd7, 5'd0, 6'h21);
    prog[25] = enc_r(5'd0, 5'd8, 5'd10, 5'd4, 6'h03);
    prog[26] = enc_i(6'h05, 5'd1, 5'd2, 16'h0003);
    prog[30] = enc_i(6'h08, 5'd0, 5'd6, 16'h0030);
    prog[31] = enc_j(6'h02, 26'h23);
    prog[35] = enc_j(6'h03, 26'h27);
    prog[39] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);

    // Expected writebacks for one pass, in program order
    add_exp(5'd1, 32'h000000AB);
    add_exp(5'd2, 32'h00003C00);
    add_exp(5'd3, 32'h00003CAB);
    add_exp(5'd3, 32'hFFFFC4AB);
    add_exp(5'd3, 32'h00003CAB);
    add_exp(5'd3, 32'hFFFFC4AB);
    add_exp(5'd3, 32'h00000000);
    add_exp(5'd3, 32'h00003CAB);
    add_exp(5'd3, 32'hFFFFC354);
    add_exp(5'd3, 32'h00003CAB);
    add_exp(5'd3, 32'h00000000);
    add_exp(5'd3, 32'h00001111);
    add_exp(5'd3, 32'h00000156);
    add_exp(5'd3, 32'h00000055);
    add_exp(5'd3, 32'h00000055);
    add_exp(5'd3, 32'h01E00000);
    add_exp(5'd3, 32'h00000007);
    add_exp(5'd3, 32'h00000007);
    add_exp(5'd3, 32'h00000001);
    add_exp(5'd8, 32'hFFFFFFFF);
    add_exp(5'd9, 32'h00000001);
    add_exp(5'd4, 32'h000000AB);
    add_exp(5'd7, 32'h00000156);
    add_exp(5'd10, 32'hFFFFFFFF);
    add_exp(5'd6, 32'h00000030);
    add_exp(5'd31, 32'h00000090);

    // Memory preload
    for (int i = 0; i < 256; i++) begin
      dut.instrMemory[i] = 32'h0;
      dut.dataMemory[i]  = 32'h0;
    end
    for (int i = 0; i < 43; i++) dut.instrMemory[i] = prog[i];
    dut.dataMemory[0] = 32'h000000AB;
    dut.dataMemory[1] = 32'h00003C00;
    dut.dataMemory[2] = 32'hDEADBEEF;

    push_pass();
    push_pass();

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_pc", dut.PC, 32'h0);
    check("rst_instr", dut.instr, 32'h0);
    check("rst_gr31", dut.gr[31], 32'h0);
    mon_on = 1'b1;
    reset_n = 1'b1;

    // First fetch after reset comes from address 0
    @(posedge clock);
    #1;
    check("first_instr", dut.instr, prog[0]);
    check("first_pc", dut.PC, 32'h4);

    // First pass
    drain_to("drain_pass1", pass.size(), 500);
    @(negedge clock);
    check("dmem2_sw", dut.dataMemory[2], 32'h0);
    check("gr31_jal", dut.gr[31], 32'h90);
    check("gr5_skipped", dut.gr[5], 32'h0);
    check("gr6_target", dut.gr[6], 32'h30);
    check("seen_pc_8c", {31'd0, seen_8c}, 32'd1);
    check("seen_pc_9c", {31'd0, seen_9c}, 32'd1);

    // Part-way through the replay, reset asynchronously
    drain_to("drain_mid", pass.size() - 12, 500);
    check("replay_pc0", {31'd0, seen_ret}, 32'd1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_pc", dut.PC, 32'h0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc = acc | dut.gr[i];
    check("midrst_gr_or", acc, 32'h0);
    check("midrst_wb", {31'd0, dut.wb_wr_q}, 32'd0);
    check("midrst_dmem0", dut.dataMemory[0], 32'h000000AB);
    check("midrst_dmem1", dut.dataMemory[1], 32'h00003C00);
    check("midrst_dmem2", dut.dataMemory[2], 32'h0);
    bad = 0;
    for (int i = 0; i < 43; i++) if (dut.instrMemory[i] !== prog[i]) bad++;
    check("midrst_imem", bad, 32'd0);
    exp_q.delete();
    push_pass();
    repeat (2) @(negedge clock);
    check("midrst_hold_pc", dut.PC, 32'h0);
    reset_n = 1'b1;

    // Full pass after the mid-program reset
    drain_to("drain_pass3", 0, 500);
    mon_on = 1'b0;
    @(negedge clock);
    check("final_gr3", dut.gr[3], 32'h1);
    check("final_gr10", dut.gr[10], 32'hFFFFFFFF);
    check("final_gr31", dut.gr[31], 32'h90);
    check("final_gr0", dut.gr[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
